// File: rtl/chan_incr_pipe.sv
// Per-channel add-with-carry of a shared step, with wrap/saturate mode,
// buffered through a 2-entry result FIFO with valid/ready handshakes on both sides.
module chan_incr_pipe #(
  parameter int WIDTH  = 40,
  parameter int NCHAN  = 3,
  parameter int STEP_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCHAN*WIDTH-1:0] in_data,
  input  logic [STEP_W-1:0]      in_step,
  input  logic                   in_sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCHAN*WIDTH-1:0] out_data,
  output logic [NCHAN-1:0]       out_ovf,
  output logic [CNT_W-1:0]       xfer_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NCHAN*WIDTH-1:0] r_head_data;
  logic [NCHAN-1:0]       r_head_ovf;
  logic [NCHAN*WIDTH-1:0] r_tail_data;
  logic [NCHAN-1:0]       r_tail_ovf;
  logic [CNT_W-1:0]       r_xfer_count;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_load_head;
  logic                   w_load_tail;
  logic                   w_shift;
  logic [NCHAN*WIDTH-1:0] w_res_data;
  logic [NCHAN-1:0]       w_res_ovf;
  logic [WIDTH:0]         w_sum;

  assign in_ready   = !reset && (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_head_data;
  assign out_ovf    = r_head_ovf;
  assign xfer_count = r_xfer_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Channels are summed one bit wider than the datum so each carry stays local.
  always_comb begin
    w_sum      = '0;
    w_res_data = '0;
    w_res_ovf  = '0;
    for (int c = 0; c < NCHAN; c++) begin
      w_sum        = {1'b0, in_data[c*WIDTH +: WIDTH]} + (WIDTH+1)'(in_step);
      w_res_ovf[c] = w_sum[WIDTH];
      if (in_sat && w_sum[WIDTH]) begin
        w_res_data[c*WIDTH +: WIDTH] = {WIDTH{1'b1}};
      end else begin
        w_res_data[c*WIDTH +: WIDTH] = w_sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_head = 1'b0;
    w_load_tail = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_load_head = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_state_nxt = ST_FULL;
            w_load_tail = 1'b1;
          end
          2'b01:   w_state_nxt = ST_EMPTY;
          // Simultaneous push/pop: the new result replaces the departing head.
          2'b11: begin
            w_state_nxt = ST_ONE;
            w_load_head = 1'b1;
          end
          default: w_state_nxt = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt = ST_ONE;
          w_shift     = 1'b1;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head_data <= '0;
      r_head_ovf  <= '0;
      r_tail_data <= '0;
      r_tail_ovf  <= '0;
    end else begin
      if (w_load_head) begin
        r_head_data <= w_res_data;
        r_head_ovf  <= w_res_ovf;
      end else if (w_shift) begin
        r_head_data <= r_tail_data;
        r_head_ovf  <= r_tail_ovf;
      end else begin
        r_head_data <= r_head_data;
        r_head_ovf  <= r_head_ovf;
      end
      if (w_load_tail) begin
        r_tail_data <= w_res_data;
        r_tail_ovf  <= w_res_ovf;
      end else begin
        r_tail_data <= r_tail_data;
        r_tail_ovf  <= r_tail_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (w_pop) begin
      r_xfer_count <= r_xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_xfer_count <= r_xfer_count;
    end
  end

endmodule
